// File: rtl/pad_arb_if.sv
// pad_arb_if: command / response bundle between the requesters and pad_arb.
//   cmd_valid[1:0]  requester command valid (bit n = requester n)
//   cmd_ready[1:0]  per-requester accept from the arbiter
//   cmd_wr[1:0]     1 = drive the pad, 0 = sample the pad
//   cmd_bit[1:0]    bit to drive on a write
//   cmd_pull[3:0]   read pull, [2n+1:2n]; 10 = down, 11 = up, 00 = none
//   idle_pull[1:0]  pull applied while the pad is idle
//   rsp_valid       response available
//   rsp_ready       response consumer accept
//   rsp_id          requester the response belongs to
//   rsp_data        sampled pad value (reads), 0 for writes
// slave = arbiter side, master = requester/consumer side.
interface pad_arb_if;
    logic [1:0] cmd_valid;
    logic [1:0] cmd_ready;
    logic [1:0] cmd_wr;
    logic [1:0] cmd_bit;
    logic [3:0] cmd_pull;
    logic [1:0] idle_pull;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic       rsp_data;

    modport slave (
        input  cmd_valid, cmd_wr, cmd_bit, cmd_pull, idle_pull, rsp_ready,
        output cmd_ready, rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output cmd_valid, cmd_wr, cmd_bit, cmd_pull, idle_pull, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/pad_arb.sv
// pad_arb: two-requester round-robin arbiter for a single bidirectional pad.
// A write drives the pad for HOLD_CYC cycles then releases it for TURN_CYC
// cycles; a read holds the pad in input mode with the requested pull for
// SAMPLE_CYC cycles and captures the synchronized pad value. Every command
// ends with one response on the rsp_* handshake.
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   bus       pad_arb_if.slave command / response bundle
//   pad_din   data to the pad
//   pad_oen   0 = pad drives pad_din, 1 = input / high-Z
//   pad_pull  pad pull select
//   pad_dout  pad input value (asynchronous to clk)
module pad_arb #(
    parameter int HOLD_CYC   = 4,
    parameter int TURN_CYC   = 1,
    parameter int SAMPLE_CYC = 3
) (
    input  logic         clk,
    input  logic         rst,
    pad_arb_if.slave     bus,
    output logic         pad_din,
    output logic         pad_oen,
    output logic [1:0]   pad_pull,
    input  logic         pad_dout
);

    typedef enum logic [2:0] {IDLE, DRIVE, TURN, SAMPLE, RESP} state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       ptr_q, ptr_d;
    logic       id_q, id_d;
    logic       bit_q, bit_d;
    logic [1:0] pull_q, pull_d;
    logic       sync1_q, sync2_q;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_data_q, rsp_data_d;
    logic       pad_din_q, pad_din_d;
    logic       pad_oen_q, pad_oen_d;
    logic [1:0] pad_pull_q, pad_pull_d;

    logic       gnt;
    logic [1:0] ready;
    logic       accept;
    logic [1:0] sel_pull;

    // Arbitration: a lone requester wins, a tie goes to the pointer.
    always_comb begin
        gnt   = ptr_q;
        ready = 2'b00;
        case (bus.cmd_valid)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            default: gnt = ptr_q;
        endcase
        if (state_q == IDLE && bus.cmd_valid != 2'b00) begin
            ready = gnt ? 2'b10 : 2'b01;
        end
    end

    assign accept   = (bus.cmd_valid & ready) != 2'b00;
    assign sel_pull = gnt ? bus.cmd_pull[3:2] : bus.cmd_pull[1:0];

    // Next state, command latch and response capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 8'd1;
        ptr_d      = ptr_q;
        id_d       = id_q;
        bit_d      = bit_q;
        pull_d     = pull_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (accept) begin
                    id_d    = gnt;
                    bit_d   = bus.cmd_bit[gnt];
                    // 01 is not a valid pull code and behaves as "none".
                    pull_d  = (sel_pull == 2'b01) ? 2'b00 : sel_pull;
                    ptr_d   = ~gnt;
                    state_d = bus.cmd_wr[gnt] ? DRIVE : SAMPLE;
                end
            end
            DRIVE: begin
                if (cnt_q == 8'(HOLD_CYC - 1)) begin
                    state_d = TURN;
                    cnt_d   = 8'd0;
                end
            end
            TURN: begin
                if (cnt_q == 8'(TURN_CYC - 1)) begin
                    state_d    = RESP;
                    rsp_data_d = 1'b0;
                    cnt_d      = 8'd0;
                end
            end
            SAMPLE: begin
                if (cnt_q == 8'(SAMPLE_CYC - 1)) begin
                    state_d    = RESP;
                    rsp_data_d = sync2_q;
                    cnt_d      = 8'd0;
                end
            end
            RESP: begin
                cnt_d = 8'd0;
                if (rsp_valid_q && bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // rsp_valid rises one cycle after entering RESP and drops on the
    // handshake edge, so it never lingers once the FSM is back in IDLE.
    assign rsp_valid_d = (state_q == RESP) && !(rsp_valid_q && bus.rsp_ready);

    // Pad outputs are decoded from the next state and registered, so the
    // pad pins line up exactly with the state they belong to.
    always_comb begin
        pad_oen_d  = 1'b1;
        pad_din_d  = 1'b0;
        pad_pull_d = 2'b00;
        case (state_d)
            DRIVE: begin
                pad_oen_d = 1'b0;
                pad_din_d = bit_d;
            end
            SAMPLE:    pad_pull_d = pull_d;
            IDLE, RESP: pad_pull_d = bus.idle_pull;
            default:   pad_pull_d = 2'b00;
        endcase
    end

    // ---- register stage: control, synchronizer and pad pins ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            ptr_q       <= 1'b0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            pad_oen_q   <= 1'b1;
            pad_din_q   <= 1'b0;
            pad_pull_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            sync1_q     <= pad_dout;
            sync2_q     <= sync1_q;
            pad_oen_q   <= pad_oen_d;
            pad_din_q   <= pad_din_d;
            pad_pull_q  <= pad_pull_d;
        end
    end

    // Latched command payload only matters while a command is in flight.
    always_ff @(posedge clk) begin
        bit_q  <= bit_d;
        pull_q <= pull_d;
    end

    assign bus.cmd_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign pad_oen       = pad_oen_q;
    assign pad_din       = pad_din_q;
    assign pad_pull      = pad_pull_q;

endmodule

// File: doc/pad_arb.md
PAD_ARB -- requirements
Module: pad_arb

Interface
Parameters (name, default, meaning):
REQ-001 HOLD_CYC, 4, cycles the pad is driven per write command (>=1).
REQ-002 TURN_CYC, 1, bus-release cycles after a write, pad undriven (>=1).
REQ-003 SAMPLE_CYC, 3, cycles the pad is held in input mode with the command pull before capture (>=3).
Ports (name, direction, width, meaning):
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cmd_valid  input  2  per-requester command valid (bit n = requester n).
REQ-007 cmd_ready  output  2  per-requester accept; a command is taken when valid[n]&ready[n].
REQ-008 cmd_wr  input  2  per-requester: 1 = drive bit, 0 = sample pad.
REQ-009 cmd_bit  input  2  per-requester bit to drive (write only).
REQ-010 cmd_pull  input  4  per-requester pull for reads, [2n+1:2n]; 10 = down, 11 = up, 00 = none.
REQ-011 idle_pull  input  2  pull applied while the pad is idle.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  response consumer accept.
REQ-014 rsp_id  output  1  requester the response belongs to.
REQ-015 rsp_data  output  1  sampled pad value (reads); 0 for writes.
REQ-016 pad_din  output  1  data to the pad.
REQ-017 pad_oen  output  1  pad direction: 0 = pad drives pad_din, 1 = input/high-Z.
REQ-018 pad_pull  output  2  pad pull select.
REQ-019 pad_dout  input  1  pad input value (asynchronous to clk).

Function
REQ-020 The FSM SHALL have states IDLE, DRIVE, TURN, SAMPLE, RESP.
REQ-021 cmd_ready SHALL be combinational: only the granted bit is high, and only in IDLE; all bits are 0 in any other state.
REQ-022 Grant SHALL be round-robin: a single valid requester wins; if both are valid, the priority pointer wins; after each accept, the pointer SHALL move to the other requester.
REQ-023 On accept, the FSM SHALL latch id, wr, bit and pull; ignore other cmd_* changes until the next IDLE.
REQ-024 IDLE -> DRIVE on an accepted write; IDLE -> SAMPLE on an accepted read; no valid -> stay IDLE.
REQ-025 DRIVE SHALL last HOLD_CYC cycles with pad_oen = 0, pad_din = latched bit and pad_pull = 00, then go to TURN.
REQ-026 TURN SHALL last TURN_CYC cycles with pad_oen = 1 and pad_din = 0, then go to RESP with rsp_data = 0.
REQ-027 SAMPLE SHALL last SAMPLE_CYC cycles with pad_oen = 1 and pad_pull = latched pull (01 treated as 00).
REQ-028 pad_dout SHALL pass through a 2-flop synchronizer.
REQ-029 On the last SAMPLE cycle, the synchronized value SHALL be captured into rsp_data; the FSM then goes to RESP.
REQ-030 In IDLE and RESP, pad_oen SHALL be 1, pad_din SHALL be 0, and pad_pull SHALL be idle_pull (registered, one cycle of latency).
REQ-031 RESP SHALL hold rsp_valid = 1 with stable rsp_id and rsp_data until rsp_ready = 1, then return to IDLE on that edge.
REQ-032 A new command SHALL NOT be accepted in the same cycle as a response handshake.
REQ-033 Latency, accept at edge T:
  - write: rsp_valid first high at T+HOLD_CYC+TURN_CYC+1 (default T+6);
  - read: rsp_valid first high at T+SAMPLE_CYC+1 (default T+4).
REQ-034 pad_oen SHALL never be 0 in any state other than DRIVE; all pad_* outputs SHALL be registered (glitch-free).

Reset
REQ-035 While rst = 1 at an edge, all of the following SHALL hold regardless of the current state, including mid-DRIVE:
  - FSM to IDLE, pointer to requester 0;
  - pad_oen = 1, pad_din = 0, pad_pull = 00;
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0;
  - synchronizer flops = 0.
REQ-036 The first cycle after reset release SHALL be IDLE; commands are accepted from that cycle.

Verification
REQ-037 Single write: valid[0], wr = 1, bit = 1, rsp_ready = 1 -> pad_oen = 0 and pad_din = 1 for exactly 4 cycles, then 1 cycle oen = 1, then rsp_valid with rsp_id = 0 and rsp_data = 0 at T+6.
REQ-038 Read with pull-up: valid[1], wr = 0, pull = 11, pad_dout = 1 -> pad_pull = 11 for 3 cycles, pad_oen = 1 throughout, rsp_valid at T+4 with rsp_id = 1 and rsp_data = 1; repeat with pull = 10 and pad_dout = 0 -> rsp_data = 0.
REQ-039 Contention: both valid continuously after reset -> grants alternate 0,1,0,1; cmd_ready is never 2'b11.
REQ-040 Response backpressure: rsp_ready = 0 for 5 cycles -> rsp_valid, rsp_id and rsp_data stable; cmd_ready = 00 until the handshake edge.
REQ-041 Reset mid-DRIVE: rst asserted during the 2nd DRIVE cycle -> next edge gives pad_oen = 1, pad_din = 0, pad_pull = 00, rsp_valid = 0; no response is ever issued for that command.
REQ-042 Idle pull tracking: in IDLE, idle_pull changes 00 -> 11 -> 10 -> pad_pull follows one cycle later; a bench assertion checks pad_oen = 0 only in DRIVE.
